// File: rtl/subsys_lifecycle_resp.sv
// Lifecycle responder for one local subsystem.
// Accepts INIT / SHUTDOWN / HEALTH requests one at a time, drives one-cycle
// start/stop pulses to the subsystem, waits for done/fail and returns a
// tagged response with a valid/ready handshake.
// Optional completion timeout: define SUBSYS_RESP_TIMEOUT_EN to enable it.
module subsys_lifecycle_resp #(
  parameter int ID_W    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [ID_W-1:0] req_id,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [1:0]      rsp_status,
  output logic [ID_W-1:0] rsp_id,
  output logic            sub_start,
  output logic            sub_stop,
  input  logic            sub_done,
  input  logic            sub_fail,
  output logic [2:0]      state_o
);

  localparam logic [2:0] ST_OFF      = 3'd0;
  localparam logic [2:0] ST_INITING  = 3'd1;
  localparam logic [2:0] ST_READY    = 3'd2;
  localparam logic [2:0] ST_STOPPING = 3'd3;
  localparam logic [2:0] ST_FAULT    = 3'd4;

  localparam logic [1:0] OP_INIT     = 2'b00;
  localparam logic [1:0] OP_SHUTDOWN = 2'b01;
  localparam logic [1:0] OP_HEALTH   = 2'b10;

  localparam logic [1:0] RS_OK      = 2'b00;
  localparam logic [1:0] RS_BAD     = 2'b01;
  localparam logic [1:0] RS_FAIL    = 2'b10;
  localparam logic [1:0] RS_TIMEOUT = 2'b11;

  // The counter is 16 bits wide, so only 1..65535 is meaningful.
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..65535");
  end

  logic [2:0]      state_q, state_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [1:0]      rsp_status_q, rsp_status_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic            sub_start_q, sub_start_d;
  logic            sub_stop_q, sub_stop_d;

  logic idle_state;
  logic busy;
  logic accept;
  logic pulse_cycle;
  logic fail_ev;
  logic done_ev;

  assign idle_state  = (state_q == ST_OFF) || (state_q == ST_READY) || (state_q == ST_FAULT);
  assign busy        = (state_q == ST_INITING) || (state_q == ST_STOPPING);
  // Combinational ready is also masked by rst so it reads 0 while reset is held.
  assign req_ready   = idle_state && !rsp_valid_q && !rst;
  assign accept      = req_valid && req_ready;
  // Completion inputs are not trusted in the cycle the start/stop pulse is out.
  assign pulse_cycle = sub_start_q || sub_stop_q;
  assign fail_ev     = busy && !pulse_cycle && sub_fail;
  assign done_ev     = busy && !pulse_cycle && sub_done && !sub_fail;

`ifdef SUBSYS_RESP_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_hit;

  // Count cycles spent in INITING/STOPPING; the counter sits at zero while
  // idle, so entering a busy state always starts from zero.
  always_comb begin
    tmo_cnt_d = busy ? tmo_cnt_q + 16'd1 : 16'd0;
  end

  assign tmo_hit = busy && (tmo_cnt_q == TMO_LAST);

  // Timeout counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= 16'd0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  // Next-state, response and pulse decisions.
  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_status_d = rsp_status_q;
    rsp_id_d     = rsp_id_q;
    sub_start_d  = 1'b0;
    sub_stop_d   = 1'b0;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    if (accept) begin
      // rsp_valid is low here, so the id can be latched without disturbing
      // a held response.
      rsp_id_d = req_id;
      case (req_op)
        OP_INIT: begin
          if (state_q == ST_READY) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = RS_BAD;
          end else begin
            state_d     = ST_INITING;
            sub_start_d = 1'b1;
          end
        end
        OP_SHUTDOWN: begin
          if (state_q == ST_OFF) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = RS_OK;
          end else begin
            state_d    = ST_STOPPING;
            sub_stop_d = 1'b1;
          end
        end
        OP_HEALTH: begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = (state_q == ST_READY) ? RS_OK : RS_BAD;
        end
        default: begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = RS_BAD;
        end
      endcase
    end else if (fail_ev) begin
      state_d      = ST_FAULT;
      rsp_valid_d  = 1'b1;
      rsp_status_d = RS_FAIL;
    end else if (done_ev) begin
      state_d      = (state_q == ST_INITING) ? ST_READY : ST_OFF;
      rsp_valid_d  = 1'b1;
      rsp_status_d = RS_OK;
    end
`ifdef SUBSYS_RESP_TIMEOUT_EN
    else if (tmo_hit) begin
      state_d      = ST_FAULT;
      rsp_valid_d  = 1'b1;
      rsp_status_d = RS_TIMEOUT;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_OFF;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= RS_OK;
      rsp_id_q     <= '0;
      sub_start_q  <= 1'b0;
      sub_stop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_id_q     <= rsp_id_d;
      sub_start_q  <= sub_start_d;
      sub_stop_q   <= sub_stop_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_id     = rsp_id_q;
  assign sub_start  = sub_start_q;
  assign sub_stop   = sub_stop_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_subsys_lifecycle_resp.sv
// Testbench for subsys_lifecycle_resp: directed scenarios plus a randomized
// run checked against a lifecycle model kept in the bench.
module tb_subsys_lifecycle_resp;

  localparam int ID_W = 3;
  localparam int TMO  = 8;

  localparam int S_OFF = 0, S_INITING = 1, S_READY = 2, S_STOPPING = 3, S_FAULT = 4;
  localparam logic [1:0] R_OK = 2'd0, R_BAD = 2'd1, R_FAIL = 2'd2, R_TMO = 2'd3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic [1:0]      req_op = 2'd0;
  logic [ID_W-1:0] req_id = '0;
  logic            rsp_ready = 1'b0;
  logic            sub_done = 1'b0;
  logic            sub_fail = 1'b0;
  logic            req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_status;
  logic [ID_W-1:0] rsp_id;
  logic            sub_start;
  logic            sub_stop;
  logic [2:0]      state_o;

  int compared = 0;
  int mismatched = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  int both_cnt = 0;
  int m_state = S_OFF;

  always #5 clk = ~clk;

  subsys_lifecycle_resp #(.ID_W(ID_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_id(req_id),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_id(rsp_id),
    .sub_start(sub_start), .sub_stop(sub_stop), .sub_done(sub_done), .sub_fail(sub_fail),
    .state_o(state_o)
  );

  // Pulse bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    if (sub_start) start_cnt <= start_cnt + 1;
    if (sub_stop) stop_cnt <= stop_cnt + 1;
    if (sub_start && sub_stop) both_cnt <= both_cnt + 1;
  end

  // Lifecycle rules: kind 0 = immediate response, 1 = start pulse, 2 = stop pulse.
  function automatic void model_accept(input logic [1:0] op, output int kind,
                                       output logic [1:0] st, output int nxt);
    kind = 0; st = R_BAD; nxt = m_state;
    case (op)
      2'd0: if (m_state == S_OFF || m_state == S_FAULT) begin kind = 1; nxt = S_INITING; end
      2'd1: if (m_state == S_READY || m_state == S_FAULT) begin kind = 2; nxt = S_STOPPING; end
            else st = R_OK;
      2'd2: if (m_state == S_READY) st = R_OK;
      default: ;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; sub_done = 1'b0; sub_fail = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_state = S_OFF;
    @(posedge clk); #1;
  endtask

  task automatic consume_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // Issue a request whose acceptance is known to be possible; returns at E0+1.
  task automatic issue(input logic [1:0] op, input logic [ID_W-1:0] id);
    req_valid = 1'b1; req_op = op; req_id = id;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // outcome: 0 done, 1 fail, 2 done+fail together. dly >= 1.
  task automatic run_op(input logic [1:0] op, input logic [ID_W-1:0] id, input int outcome,
                        input int dly, input int rdy_dly);
    int kind, nxt, n, s0, p0;
    logic [1:0] est;
    model_accept(op, kind, est, nxt);
    s0 = start_cnt; p0 = stop_cnt;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++; $display("FAIL req_ready_wait: req_ready=%b required 1", req_ready);
    end
    issue(op, id);
    m_state = nxt;
    compared++;
    if (state_o !== 3'(m_state)) begin
      mismatched++; $display("FAIL accept_state op=%0d: state=%0d required %0d", op, state_o, m_state);
    end
    if (kind == 0) begin
      compared++;
      if (rsp_valid !== 1'b1 || rsp_status !== est || rsp_id !== id || sub_start !== 1'b0 || sub_stop !== 1'b0) begin
        mismatched++;
        $display("FAIL imm_rsp op=%0d: valid=%b status=%0d id=%0d start=%b stop=%b required valid=1 status=%0d id=%0d no pulse",
                 op, rsp_valid, rsp_status, rsp_id, sub_start, sub_stop, est, id);
      end
    end else begin
      compared++;
      if (sub_start !== (kind == 1) || sub_stop !== (kind == 2) || rsp_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL pulse_on op=%0d: start=%b stop=%b valid=%b required start=%b stop=%b valid=0",
                 op, sub_start, sub_stop, rsp_valid, kind == 1, kind == 2);
      end
      @(posedge clk); #1;
      compared++;
      if (sub_start !== 1'b0 || sub_stop !== 1'b0) begin
        mismatched++; $display("FAIL pulse_off: start=%b stop=%b required 0 0", sub_start, sub_stop);
      end
      for (int i = 1; i < dly; i++) begin @(posedge clk); #1; end
      sub_done = (outcome != 1); sub_fail = (outcome != 0);
      @(posedge clk); #1;
      sub_done = 1'b0; sub_fail = 1'b0;
      if (outcome == 0) begin
        est = R_OK; m_state = (m_state == S_INITING) ? S_READY : S_OFF;
      end else begin
        est = R_FAIL; m_state = S_FAULT;
      end
      compared++;
      if (state_o !== 3'(m_state) || rsp_valid !== 1'b1 || rsp_status !== est || rsp_id !== id) begin
        mismatched++;
        $display("FAIL done_rsp op=%0d outcome=%0d: state=%0d valid=%b status=%0d id=%0d required state=%0d valid=1 status=%0d id=%0d",
                 op, outcome, state_o, rsp_valid, rsp_status, rsp_id, m_state, est, id);
      end
    end
    for (int i = 0; i < rdy_dly; i++) begin
      @(posedge clk); #1;
      compared++;
      if (rsp_valid !== 1'b1 || rsp_status !== est || rsp_id !== id || req_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL rsp_hold: valid=%b status=%0d id=%0d req_ready=%b required 1 %0d %0d 0",
                 rsp_valid, rsp_status, rsp_id, req_ready, est, id);
      end
    end
    consume_rsp();
    compared++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      mismatched++; $display("FAIL rsp_drop: valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
    end
    compared++;
    if (start_cnt - s0 != int'(kind == 1) || stop_cnt - p0 != int'(kind == 2)) begin
      mismatched++;
      $display("FAIL pulse_count op=%0d: starts=%0d stops=%0d required %0d %0d",
               op, start_cnt - s0, stop_cnt - p0, kind == 1, kind == 2);
    end
    $display("txn op=%0d id=%0d outcome=%0d -> state=%0d status=%0d", op, id, outcome, state_o, est);
  endtask

  task automatic test_reset();
    #2;
    compared++;
    if (state_o !== 3'd0 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_status !== 2'd0 ||
        rsp_id !== '0 || sub_start !== 1'b0 || sub_stop !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_values: state=%0d rdy=%b valid=%b status=%0d id=%0d start=%b stop=%b required all 0",
               state_o, req_ready, rsp_valid, rsp_status, rsp_id, sub_start, sub_stop);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (req_ready !== 1'b1 || state_o !== 3'd0) begin
      mismatched++; $display("FAIL reset_release: req_ready=%b state=%0d required 1 0", req_ready, state_o);
    end
    $display("txn reset -> state=%0d req_ready=%b", state_o, req_ready);
  endtask

  task automatic test_init_basic();
    do_reset();
    run_op(2'd0, 3'd5, 0, 10, 0);
  endtask

  task automatic test_health_hold();
    run_op(2'd2, 3'd2, 0, 1, 4);
  endtask

  task automatic test_shutdown_fail();
    run_op(2'd1, 3'd3, 2, 3, 0);
    run_op(2'd1, 3'd4, 0, 2, 1);
  endtask

  task automatic test_bad_state();
    do_reset();
    run_op(2'd0, 3'd1, 0, 2, 0);
    run_op(2'd0, 3'd6, 0, 1, 0);
    run_op(2'd1, 3'd0, 0, 1, 0);
    run_op(2'd3, 3'd7, 0, 1, 0);
    run_op(2'd1, 3'd2, 0, 1, 0);
  endtask

  task automatic test_ignore_window();
    do_reset();
    issue(2'd0, 3'd6);
    sub_done = 1'b1;
    @(posedge clk); #1;
    sub_done = 1'b0;
    compared++;
    if (state_o !== 3'd1 || rsp_valid !== 1'b0) begin
      mismatched++; $display("FAIL pulse_cycle_done: state=%0d valid=%b required 1 0", state_o, rsp_valid);
    end
    sub_done = 1'b1;
    @(posedge clk); #1;
    sub_done = 1'b0;
    compared++;
    if (state_o !== 3'd2 || rsp_valid !== 1'b1 || rsp_status !== R_OK || rsp_id !== 3'd6) begin
      mismatched++;
      $display("FAIL late_done: state=%0d valid=%b status=%0d id=%0d required 2 1 0 6", state_o, rsp_valid, rsp_status, rsp_id);
    end
    consume_rsp();
    m_state = S_READY;
    sub_done = 1'b1; sub_fail = 1'b1;
    @(posedge clk); #1;
    sub_done = 1'b0; sub_fail = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (state_o !== 3'd2 || rsp_valid !== 1'b0) begin
      mismatched++; $display("FAIL idle_done: state=%0d valid=%b required 2 0", state_o, rsp_valid);
    end
    $display("txn ignore_window -> state=%0d", state_o);
  endtask

  task automatic test_timeout();
    do_reset();
`ifdef SUBSYS_RESP_TIMEOUT_EN
    for (int pass = 0; pass < 2; pass++) begin
      issue(2'd0, 3'(3 + pass));
      for (int k = 1; k <= TMO; k++) begin
        @(posedge clk); #1;
        if (k < TMO) begin
          compared++;
          if (rsp_valid !== 1'b0 || state_o !== 3'd1) begin
            mismatched++; $display("FAIL tmo_wait k=%0d: valid=%b state=%0d required 0 1", k, rsp_valid, state_o);
          end
          if (pass == 1 && k == TMO - 1) sub_done = 1'b1;
        end else begin
          sub_done = 1'b0;
          compared++;
          if (pass == 0 && (rsp_valid !== 1'b1 || rsp_status !== R_TMO || state_o !== 3'd4 || rsp_id !== 3'd3)) begin
            mismatched++;
            $display("FAIL tmo_expire: valid=%b status=%0d state=%0d id=%0d required 1 3 4 3", rsp_valid, rsp_status, state_o, rsp_id);
          end
          if (pass == 1 && (rsp_valid !== 1'b1 || rsp_status !== R_OK || state_o !== 3'd2 || rsp_id !== 3'd4)) begin
            mismatched++;
            $display("FAIL tmo_precedence: valid=%b status=%0d state=%0d id=%0d required 1 0 2 4", rsp_valid, rsp_status, state_o, rsp_id);
          end
        end
      end
      consume_rsp();
      $display("txn timeout pass=%0d -> state=%0d", pass, state_o);
    end
    m_state = S_READY;
`else
    issue(2'd0, 3'd3);
    repeat (1000) @(posedge clk);
    #1;
    compared++;
    if (state_o !== 3'd1 || rsp_valid !== 1'b0) begin
      mismatched++; $display("FAIL no_timeout: state=%0d valid=%b required 1 0", state_o, rsp_valid);
    end
    sub_done = 1'b1;
    @(posedge clk); #1;
    sub_done = 1'b0;
    compared++;
    if (state_o !== 3'd2 || rsp_valid !== 1'b1 || rsp_status !== R_OK) begin
      mismatched++; $display("FAIL no_timeout_done: state=%0d valid=%b status=%0d required 2 1 0", state_o, rsp_valid, rsp_status);
    end
    consume_rsp();
    m_state = S_READY;
    $display("txn no_timeout -> state=%0d", state_o);
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(2'd0, 3'd7);
    #1 rst = 1'b1;
    #1;
    compared++;
    if (state_o !== 3'd0 || sub_start !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0 ||
        rsp_id !== '0 || rsp_status !== 2'd0) begin
      mismatched++;
      $display("FAIL async_reset: state=%0d start=%b valid=%b rdy=%b id=%0d status=%0d required 0 0 0 0 0 0",
               state_o, sub_start, rsp_valid, req_ready, rsp_id, rsp_status);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (req_ready !== 1'b1 || state_o !== 3'd0) begin
      mismatched++; $display("FAIL mid_reset_release: req_ready=%b state=%0d required 1 0", req_ready, state_o);
    end
    sub_done = 1'b1;
    @(posedge clk); #1;
    sub_done = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (state_o !== 3'd0 || rsp_valid !== 1'b0) begin
      mismatched++; $display("FAIL stale_done: state=%0d valid=%b required 0 0", state_o, rsp_valid);
    end
    m_state = S_OFF;
    $display("txn reset_mid -> state=%0d", state_o);
  endtask

  task automatic test_random();
    int r, outcome;
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 99);
      outcome = (r < 60) ? 0 : (r < 85) ? 1 : 2;
      run_op(2'($urandom_range(0, 3)), ID_W'($urandom), outcome,
             $urandom_range(1, 6), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_init_basic();
    test_health_hold();
    test_shutdown_fail();
    test_bad_state();
    test_ignore_window();
    test_timeout();
    test_reset_mid();
    test_random();
    compared++;
    if (both_cnt != 0) begin
      mismatched++; $display("FAIL pulse_overlap: overlapping cycles=%0d required 0", both_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
